// File: rtl/trng_health_pkg.sv
// ============================================================================
// Module      : trng_health_pkg
// Description : Shared types, default cutoffs and width helper for the TRNG
//               online health-test monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trng_health_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_ALARM  = 2'd2
    } health_state_e;

    localparam int unsigned c_def_warmup_samples = 64;
    localparam int unsigned c_def_rct_cutoff_lo  = 8;
    localparam int unsigned c_def_rct_cutoff_hi  = 11;
    localparam int unsigned c_def_apt_window     = 1024;
    localparam int unsigned c_def_apt_cutoff     = 589;
    localparam int unsigned c_def_fail_cnt_w     = 16;

    // Bits needed to index n values (ceil(log2(n))), never less than 1.
    function automatic int unsigned clog2_win(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trng_apt_window.sv
// ============================================================================
// Module      : trng_apt_window
// Description : Adaptive proportion test: contiguous windows of valid samples,
//               ones count compared against symmetric cutoffs at window end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trng_apt_window
    import trng_health_pkg::*;
#(
    parameter int APT_WINDOW = 1024,
    parameter int APT_CUTOFF = 589
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold_i,
    input  logic valid_i,
    input  logic bit_i,
    output logic fail_o
);

    localparam int WIN_W  = clog2_win(APT_WINDOW);
    localparam int ONES_W = WIN_W + 1;

    localparam logic [WIN_W-1:0]  c_last = WIN_W'(APT_WINDOW - 1);
    localparam logic [ONES_W-1:0] c_hi   = ONES_W'(APT_CUTOFF);
    localparam logic [ONES_W-1:0] c_lo   = ONES_W'(APT_WINDOW - APT_CUTOFF);

    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [ONES_W-1:0] ones_cnt_q, ones_cnt_d;
    logic [ONES_W-1:0] w_ones_total;
    logic              w_win_end;

    always_comb begin
        w_ones_total = ones_cnt_q + ONES_W'(bit_i);
        w_win_end    = valid_i && (win_cnt_q == c_last);
        // The closing sample is part of the total being judged.
        fail_o       = w_win_end && ((w_ones_total > c_hi) || (w_ones_total < c_lo));
        win_cnt_d    = win_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        if (hold_i) begin
            win_cnt_d  = '0;
            ones_cnt_d = '0;
        end else if (valid_i) begin
            if (w_win_end) begin
                win_cnt_d  = '0;
                ones_cnt_d = '0;
            end else begin
                win_cnt_d  = win_cnt_q + WIN_W'(1);
                ones_cnt_d = w_ones_total;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt_q  <= '0;
            ones_cnt_q <= '0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            ones_cnt_q <= ones_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/trng_health_monitor.sv
// ============================================================================
// Module      : trng_health_monitor
// Description : Online RCT/APT health monitor for the ring-oscillator TRNG.
//               APT present only when TRNG_HEALTH_APT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trng_health_monitor
    import trng_health_pkg::*;
#(
    parameter int WARMUP_SAMPLES = 64,
    parameter int RCT_CUTOFF_LO  = 8,
    parameter int RCT_CUTOFF_HI  = 11,
    parameter int APT_WINDOW     = 1024,
    parameter int APT_CUTOFF     = 589,
    parameter int FAIL_CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dff_en,
    input  logic                  random_bit,
    input  logic                  clear_alarms,
    output logic                  testing,
    output logic                  rct_warn,
    output logic                  rct_fail,
    output logic                  apt_fail,
    output logic                  alarm,
    output logic [FAIL_CNT_W-1:0] rct_fail_cnt,
    output logic [FAIL_CNT_W-1:0] apt_fail_cnt
);

    localparam int REP_W  = clog2_win(RCT_CUTOFF_HI + 2);
    localparam int WARM_W = clog2_win(WARMUP_SAMPLES + 1);

    localparam logic [REP_W-1:0]  c_rep_lo   = REP_W'(RCT_CUTOFF_LO);
    localparam logic [REP_W-1:0]  c_rep_hi   = REP_W'(RCT_CUTOFF_HI);
    localparam logic [REP_W-1:0]  c_rep_max  = REP_W'(RCT_CUTOFF_HI + 1);
    localparam logic [WARM_W-1:0] c_warm_end = WARM_W'(WARMUP_SAMPLES);

    health_state_e         state_q, state_d;
    logic [WARM_W-1:0]     warm_cnt_q, warm_cnt_d;
    logic [REP_W-1:0]      rep_cnt_q, rep_cnt_d;
    logic                  prev_bit_q, prev_bit_d;
    logic                  first_q, first_d;
    logic                  testing_q, rct_warn_q, rct_fail_q, apt_fail_q, alarm_q;
    logic [FAIL_CNT_W-1:0] rct_fail_cnt_q, rct_fail_cnt_d;
    logic [FAIL_CNT_W-1:0] apt_fail_cnt_q, apt_fail_cnt_d;
    logic [FAIL_CNT_W-1:0] w_rct_base, w_apt_base;

    logic w_sample, w_rct_warn, w_rct_fail, w_apt_raw, w_apt_fail, w_any_fail;
    logic w_hold;

    assign w_sample   = dff_en && (state_q != ST_WARMUP);
    assign w_apt_fail = w_sample && w_apt_raw;
    assign w_any_fail = w_rct_fail || w_apt_fail;
    // Test state is wiped during warm-up and on any clear that a fail did not override.
    assign w_hold     = (state_q == ST_WARMUP) || (clear_alarms && !w_any_fail);

`ifdef TRNG_HEALTH_APT_EN
    trng_apt_window #(
        .APT_WINDOW (APT_WINDOW),
        .APT_CUTOFF (APT_CUTOFF)
    ) u_apt (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (w_hold),
        .valid_i (w_sample),
        .bit_i   (random_bit),
        .fail_o  (w_apt_raw)
    );
`else
    logic w_unused_apt;
    assign w_unused_apt = ^{APT_WINDOW[0], APT_CUTOFF[0]};
    assign w_apt_raw    = 1'b0;
`endif

    always_comb begin
        rep_cnt_d  = rep_cnt_q;
        prev_bit_d = prev_bit_q;
        first_d    = first_q;
        w_rct_warn = 1'b0;
        w_rct_fail = 1'b0;
        if (w_sample) begin
            if (first_q) begin
                prev_bit_d = random_bit;
                rep_cnt_d  = '0;
                first_d    = 1'b0;
            end else if (random_bit == prev_bit_q) begin
                if (rep_cnt_q != c_rep_max) begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
                w_rct_warn = (rep_cnt_q == c_rep_lo);
                w_rct_fail = (rep_cnt_q == c_rep_hi);
            end else begin
                prev_bit_d = random_bit;
                rep_cnt_d  = '0;
            end
        end
        if (w_hold) begin
            rep_cnt_d  = '0;
            prev_bit_d = 1'b0;
            first_d    = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        if (w_any_fail) begin
            state_d = ST_ALARM;
        end else if (clear_alarms) begin
            state_d    = ST_WARMUP;
            warm_cnt_d = WARM_W'(dff_en);
        end else if ((state_q == ST_WARMUP) && dff_en) begin
            warm_cnt_d = warm_cnt_q + WARM_W'(1);
        end
        if ((state_d == ST_WARMUP) && (warm_cnt_d == c_warm_end)) begin
            state_d    = ST_RUN;
            warm_cnt_d = '0;
        end
    end

    // A clear coinciding with a fail still zeroes the counters before the increment.
    always_comb begin
        w_rct_base     = clear_alarms ? '0 : rct_fail_cnt_q;
        w_apt_base     = clear_alarms ? '0 : apt_fail_cnt_q;
        rct_fail_cnt_d = w_rct_base + FAIL_CNT_W'(w_rct_fail && (w_rct_base != '1));
        apt_fail_cnt_d = w_apt_base + FAIL_CNT_W'(w_apt_fail && (w_apt_base != '1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_WARMUP;
            warm_cnt_q     <= '0;
            rep_cnt_q      <= '0;
            prev_bit_q     <= 1'b0;
            first_q        <= 1'b1;
            testing_q      <= 1'b0;
            rct_warn_q     <= 1'b0;
            rct_fail_q     <= 1'b0;
            apt_fail_q     <= 1'b0;
            alarm_q        <= 1'b0;
            rct_fail_cnt_q <= '0;
            apt_fail_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            warm_cnt_q     <= warm_cnt_d;
            rep_cnt_q      <= rep_cnt_d;
            prev_bit_q     <= prev_bit_d;
            first_q        <= first_d;
            testing_q      <= (state_d != ST_WARMUP);
            rct_warn_q     <= w_rct_warn;
            rct_fail_q     <= w_rct_fail;
            apt_fail_q     <= w_apt_fail;
            alarm_q        <= (state_d == ST_ALARM);
            rct_fail_cnt_q <= rct_fail_cnt_d;
            apt_fail_cnt_q <= apt_fail_cnt_d;
        end
    end

    assign testing      = testing_q;
    assign rct_warn     = rct_warn_q;
    assign rct_fail     = rct_fail_q;
    assign apt_fail     = apt_fail_q;
    assign alarm        = alarm_q;
    assign rct_fail_cnt = rct_fail_cnt_q;
    assign apt_fail_cnt = apt_fail_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_trng_health_monitor.sv
// ============================================================================
// Module      : tb_trng_health_monitor
// Description : Directed self-checking bench for trng_health_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trng_health_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dff_en = 1'b0;
    logic        random_bit = 1'b0;
    logic        clear_alarms = 1'b0;
    logic        testing, rct_warn, rct_fail, apt_fail, alarm;
    logic [15:0] rct_fail_cnt, apt_fail_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    trng_health_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dff_en       (dff_en),
        .random_bit   (random_bit),
        .clear_alarms (clear_alarms),
        .testing      (testing),
        .rct_warn     (rct_warn),
        .rct_fail     (rct_fail),
        .apt_fail     (apt_fail),
        .alarm        (alarm),
        .rct_fail_cnt (rct_fail_cnt),
        .apt_fail_cnt (apt_fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        b;
        logic        clr;
        logic        testing;
        logic        warn;
        logic        fail;
        logic        alarm;
        logic [15:0] rcnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic b, input logic clr);
        @(negedge clk);
        dff_en       = en;
        random_bit   = b;
        clear_alarms = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        dff_en       = 1'b1;
        random_bit   = 1'b1;
        clear_alarms = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {27'd0, testing, rct_warn, rct_fail, apt_fail, alarm}, 32'd0);
        chk("reset_counts", {rct_fail_cnt, apt_fail_cnt}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        dff_en = 1'b0;
    endtask

    task automatic warmup();
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'(i & 1), 1'b0);
            chk("warmup_testing", {31'd0, testing}, {31'd0, (i == 63)});
        end
    endtask

    function automatic logic bres(input int i, input int k);
        return ((((i + 1) * k) / 1024) - ((i * k) / 1024)) != 0;
    endfunction

    initial begin
        // Table: warm-up, 13-ones RCT run, then 20 further ones.
        for (int i = 0; i < 64; i++)
            tbl.push_back('{en: 1'b1, b: 1'(i & 1), clr: 1'b0, testing: (i == 63),
                            warn: 1'b0, fail: 1'b0, alarm: 1'b0, rcnt: 16'd0});
        for (int i = 1; i <= 13; i++)
            tbl.push_back('{en: 1'b1, b: 1'b1, clr: 1'b0, testing: 1'b1,
                            warn: (i == 10), fail: (i == 13), alarm: (i == 13),
                            rcnt: (i == 13) ? 16'd1 : 16'd0});
        for (int i = 0; i < 20; i++)
            tbl.push_back('{en: 1'b1, b: 1'b1, clr: 1'b0, testing: 1'b1,
                            warn: 1'b0, fail: 1'b0, alarm: 1'b1, rcnt: 16'd1});

        do_reset();
        foreach (tbl[k]) begin
            step(tbl[k].en, tbl[k].b, tbl[k].clr);
            chk("tbl_flags", {28'd0, testing, rct_warn, rct_fail, alarm},
                {28'd0, tbl[k].testing, tbl[k].warn, tbl[k].fail, tbl[k].alarm});
            chk("tbl_rct_cnt", {16'd0, rct_fail_cnt}, {16'd0, tbl[k].rcnt});
            chk("tbl_apt_fail", {31'd0, apt_fail}, 32'd0);
        end

        // 13 ones with dff_en 1-in-3; invalid cycles carry opposite/garbage bits.
        do_reset();
        warmup();
        for (int k = 1; k <= 13; k++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("sparse_pulses", {30'd0, rct_warn, rct_fail}, {30'd0, (k == 10), (k == 13)});
            step(1'b0, 1'b0, 1'b0);
            chk("sparse_idle0", {30'd0, rct_warn, rct_fail}, 32'd0);
            step(1'b0, 1'b1, 1'b0);
            chk("sparse_idle1", {30'd0, rct_warn, rct_fail}, 32'd0);
        end
        chk("sparse_alarm", {31'd0, alarm}, 32'd1);
        chk("sparse_rct_cnt", {16'd0, rct_fail_cnt}, 32'd1);

        // Clear coincident with a fail-triggering sample: the fail wins.
        step(1'b1, 1'b0, 1'b0);
        chk("break_run", {30'd0, rct_warn, rct_fail}, 32'd0);
        for (int k = 1; k <= 13; k++) begin
            step(1'b1, 1'b1, (k == 13));
            chk("clrfail_pulses", {30'd0, rct_warn, rct_fail}, {30'd0, (k == 10), (k == 13)});
        end
        chk("clrfail_cnt", {16'd0, rct_fail_cnt}, 32'd1);
        chk("clrfail_alarm_testing", {30'd0, alarm, testing}, 32'd3);

        // Clear alone: everything drops, this sample is warm-up sample 1.
        step(1'b1, 1'b0, 1'b1);
        chk("clear_flags", {27'd0, testing, rct_warn, rct_fail, apt_fail, alarm}, 32'd0);
        chk("clear_counts", {rct_fail_cnt, apt_fail_cnt}, 32'd0);
        for (int j = 2; j <= 64; j++) begin
            step(1'b1, 1'(j & 1), 1'b0);
            chk("rewarm_testing", {31'd0, testing}, {31'd0, (j == 64)});
        end

`ifdef TRNG_HEALTH_APT_EN
        begin
            int ks[4];
            logic exp_fail[4];
            int exp_cnt;
            ks = '{590, 512, 435, 434};
            exp_fail = '{1'b1, 1'b0, 1'b0, 1'b1};
            exp_cnt = 0;
            do_reset();
            warmup();
            for (int w = 0; w < 4; w++) begin
                for (int i = 0; i < 1024; i++) begin
                    if (i == 500) begin
                        step(1'b0, 1'b1, 1'b0);
                        chk("apt_idle", {31'd0, apt_fail}, 32'd0);
                    end
                    step(1'b1, bres(i, ks[w]), 1'b0);
                    chk("apt_pulse", {31'd0, apt_fail}, {31'd0, (i == 1023) && exp_fail[w]});
                end
                if (exp_fail[w]) exp_cnt++;
                chk("apt_cnt", {16'd0, apt_fail_cnt}, exp_cnt);
                chk("apt_alarm", {31'd0, alarm}, 32'd1);
            end
            chk("apt_rct_cnt", {16'd0, rct_fail_cnt}, 32'd0);
        end
`else
        begin
            int ones;
            int idx;
            logic b;
            ones = 0;
            idx = 0;
            do_reset();
            warmup();
            while (ones < 1024) begin
                b = (idx % 10) != 9;
                step(1'b1, b, 1'b0);
                chk("noapt_flags", {30'd0, apt_fail, alarm}, 32'd0);
                ones = ones + int'(b);
                idx++;
            end
            chk("noapt_counts", {rct_fail_cnt, apt_fail_cnt}, 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/trng_health_monitor.md
# trng_health_monitor

Synthesizable online health-test monitor for the ring-oscillator TRNG. It sits directly downstream of `top_level_RO`, consuming `random_bit` qualified by `dff_en`. It runs a continuous repetition count test (RCT) with warning and failure cutoffs, and a windowed adaptive proportion test (APT). It reports per-event pulses, saturating failure counters and a sticky alarm to the consumer of the entropy stream.

## Interface
Parameters:
- `WARMUP_SAMPLES`, 64: valid samples discarded after reset/clear before testing starts (RO settling).
- `RCT_CUTOFF_LO`, 8: repetition count above which `rct_warn` fires (alpha = 0.01).
- `RCT_CUTOFF_HI`, 11: repetition count above which `rct_fail` fires (alpha = 0.001).
- `APT_WINDOW`, 1024: APT window length in valid samples; power of two.
- `APT_CUTOFF`, 589: APT cutoff C; fail if ones > C or ones < `APT_WINDOW`-C.
- `FAIL_CNT_W`, 16: width of failure counters.

Ports:
- `clk`  in  1  single clock, shared with `top_level_RO` sampling flops.
- `rst_n`  in  1  reset; synchronous, active-low.
- `dff_en`  in  1  sample valid; `random_bit` is consumed only when high.
- `random_bit`  in  1  raw TRNG bit.
- `clear_alarms`  in  1  one-cycle request: clear sticky alarm and counters, restart warm-up.
- `testing`  out  1  high in RUN or ALARM state.
- `rct_warn`  out  1  one-cycle pulse, RCT low cutoff exceeded.
- `rct_fail`  out  1  one-cycle pulse, RCT high cutoff exceeded.
- `apt_fail`  out  1  one-cycle pulse, APT window out of bounds.
- `alarm`  out  1  sticky; set on any `rct_fail` or `apt_fail`.
- `rct_fail_cnt`  out  `FAIL_CNT_W`  saturating count of `rct_fail` pulses.
- `apt_fail_cnt`  out  `FAIL_CNT_W`  saturating count of `apt_fail` pulses.

## Operation
- FSM states are WARMUP, RUN and ALARM.
- Reset enters WARMUP. WARMUP moves to RUN after `WARMUP_SAMPLES` valid samples. RUN moves to ALARM on `rct_fail` or `apt_fail`. ALARM moves to WARMUP on `clear_alarms`.
- `clear_alarms` in WARMUP or RUN also restarts WARMUP.
- WARMUP: samples are counted and discarded. The RCT and APT state is held cleared.
- RUN and ALARM both test. ALARM differs only in holding `alarm`=1.
- RCT:
  - The first valid sample in RUN latches `prev_bit`, with `rep_cnt`=0.
  - Each later valid sample increments `rep_cnt` (saturating at `RCT_CUTOFF_HI`+1) if equal to `prev_bit`. Otherwise `rep_cnt` goes to 0 and `prev_bit` is updated.
  - `rct_warn` pulses once per run, when `rep_cnt` becomes `RCT_CUTOFF_LO`+1.
  - `rct_fail` pulses once per run, when `rep_cnt` becomes `RCT_CUTOFF_HI`+1.
- APT:
  - `ones_cnt` (log2(`APT_WINDOW`)+1 bits) and `win_cnt` count valid samples from the first valid sample in RUN.
  - On the `APT_WINDOW`-th sample, the total includes that sample and is compared against the cutoffs. `apt_fail` pulses if the total is out of bounds.
  - Both counters restart at 0 with the next sample. Windows are contiguous and non-overlapping.
- Failure counters increment on their pulse and saturate at all-ones.

## Timing
- Reset value of all outputs is 0, and state is WARMUP.
- Every output is registered. A pulse appears exactly one cycle after the `clk` edge that samples the triggering `dff_en`=1 bit.
- `dff_en`=0: no state change; all pulses are 0.
- `alarm` rises in the same cycle as the first fail pulse.
- Simultaneous `clear_alarms` and fail: the fail wins. The pulse is emitted, the counter increments from its cleared value to 1, `alarm`=1 and the state is ALARM.
- `clear_alarms` otherwise:
  - The next cycle shows `alarm`=0, both counters 0 and `testing`=0.
  - The sample presented in the clear cycle counts as warm-up sample 1.
- `rct_fail` and `apt_fail` may pulse in the same cycle. Both counters increment.
- `rst_n` low mid-window discards the partial window and any run in progress.

## Configuration
- `TRNG_HEALTH_APT_EN` defined: the APT logic is present as described.
- Undefined:
  - The APT logic is absent.
  - `apt_fail` and `apt_fail_cnt` are tied to 0.
  - Only `rct_fail` can enter ALARM.
  - The `APT_*` parameters are unused.

## Structure
- Package `trng_health_pkg`:
  - The FSM state enum `health_state_e`.
  - Default cutoff constants matching the parameter defaults.
  - Function `clog2_win` for counter widths.
- Sub-module `trng_apt_window` contains the window/ones counters and the cutoff compare. It is instantiated only under `TRNG_HEALTH_APT_EN`.
- RCT, FSM and failure counters live in the top module.

## Test plan
- Reset, then 64 valid samples alternating 0/1 → `testing` rises one cycle after the 64th sample; no pulses at any point.
- After warm-up, 13 consecutive 1s → `rct_warn` pulses after the 10th, `rct_fail` after the 13th, and `alarm`=1 with `rct_fail_cnt`=1. A further 20 ones produce no additional pulses.
- Window of 1024 samples with 590 ones → `apt_fail` after sample 1024 and `apt_fail_cnt`=1. A following window with 512 ones gives no pulse. A window with exactly 435 ones gives no pulse; a window with 434 ones gives a pulse.
- `dff_en` toggled 1-in-3 during the 13-ones run → same pulses as the contiguous case, counted in valid samples only.
- `clear_alarms` asserted in the same cycle as an `rct_fail`-triggering sample → `rct_fail_cnt`=1 and `alarm`=1. `clear_alarms` asserted alone one cycle later → all 0, and `testing` returns after 64 samples.
- `TRNG_HEALTH_APT_EN` undefined, 1024 ones interleaved with single 0s every 10 bits → no `apt_fail`, `apt_fail_cnt`=0, `alarm` stays 0.
